data_mem_bus_if: RTL and testbench

Sequential load/store bus controller in the memory stage. It takes the word-aligned store data and byte enables produced by store alignment and runs one request/acknowledge transaction per access on the data-memory bus. It stalls the pipeline while the access is outstanding and presents the captured read word to load alignment. It also detects misaligned accesses, bus errors and bus timeouts.

---
 rtl/data_mem_bus_if_if.sv | 21 ++
 rtl/data_mem_bus_if.sv | 115 +++++++++++
 tb/tb_data_mem_bus_if.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/data_mem_bus_if_if.sv
// rtl/data_mem_bus_if_if.sv - data-memory request/acknowledge bus bundle
interface data_mem_bus_if_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_ack;
    logic        bus_err;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        input  bus_ack, bus_err, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
        output bus_ack, bus_err, bus_rdata
    );
endinterface

// File: rtl/data_mem_bus_if.sv
// rtl/data_mem_bus_if.sv - memory-stage load/store controller: one req/ack bus transaction per access
module data_mem_bus_if #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      mem_read,
    input  logic                      mem_write,
    input  logic [1:0]                mem_size,
    input  logic [31:0]               addr,
    input  logic [31:0]               wdata,
    input  logic [3:0]                wsel,
    output logic                      stall,
    output logic [31:0]               rdata,
    output logic                      done,
    output logic                      access_fault,
    output logic                      misaligned,
    data_mem_bus_if_if.master         bus
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

    state_t        state, state_next;
    logic          access;
    logic          start;
    logic          ack_take;
    logic          timeout;
    logic          finish;
    logic [CW-1:0] cnt;

    // mem_size 11 falls into the word case via mem_size[1]
    assign misaligned = (mem_size == 2'b01) ? addr[0] :
                        mem_size[1]         ? (addr[1:0] != 2'b00) : 1'b0;
    assign access     = (mem_read | mem_write) & ~misaligned;
    assign finish     = ack_take | timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        start      = 1'b0;
        ack_take   = 1'b0;
        timeout    = 1'b0;
        stall      = 1'b0;
        case (state)
            S_IDLE: begin
                if (access) begin
                    start      = 1'b1;
                    stall      = 1'b1;
                    state_next = S_REQ;
                end
            end
            S_REQ: begin
                stall = 1'b1;
                if (bus.bus_ack) begin
                    ack_take   = 1'b1;
                    state_next = S_DONE;
                end else if (TIMEOUT_EN && cnt == CNT_LAST) begin
                    timeout    = 1'b1;
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.bus_req   <= 1'b0;
            bus.bus_we    <= 1'b0;
            bus.bus_addr  <= 32'h0;
            bus.bus_wdata <= 32'h0;
            bus.bus_be    <= 4'h0;
            rdata         <= 32'h0;
            done          <= 1'b0;
            access_fault  <= 1'b0;
            cnt           <= '0;
        end else begin
            // done/access_fault are high only in the single DONE cycle
            done         <= finish;
            access_fault <= timeout | (ack_take & bus.bus_err);
            if (start) begin
                bus.bus_req   <= 1'b1;
                bus.bus_we    <= mem_write;
                bus.bus_addr  <= {addr[31:2], 2'b00};
                bus.bus_wdata <= wdata;
                bus.bus_be    <= mem_write ? wsel : 4'hF;
                cnt           <= '0;
            end else if (finish) begin
                bus.bus_req <= 1'b0;
            end else if (state == S_REQ) begin
                cnt <= cnt + 1'b1;
            end
            if (ack_take && !bus.bus_we) begin
                rdata <= bus.bus_rdata;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_bus_if.sv
// tb/tb_data_mem_bus_if.sv - cycle-table and reset-sequence bench for data_mem_bus_if
module tb_data_mem_bus_if;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_read, mem_write;
    logic [1:0]  mem_size;
    logic [31:0] addr, wdata;
    logic [3:0]  wsel;
    logic        stall, done, access_fault, misaligned;
    logic [31:0] rdata;

    int checks = 0;
    int errors = 0;

    data_mem_bus_if_if bus ();

    data_mem_bus_if #(.TIMEOUT_CYCLES(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_size     (mem_size),
        .addr         (addr),
        .wdata        (wdata),
        .wsel         (wsel),
        .stall        (stall),
        .rdata        (rdata),
        .done         (done),
        .access_fault (access_fault),
        .misaligned   (misaligned),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rd, wr;
        logic [1:0]  size;
        logic [31:0] a, wd;
        logic [3:0]  ws;
        logic        ack, err;
        logic [31:0] brd;
        logic        e_stall, e_mis, e_done, e_flt, e_req, e_we;
        logic [3:0]  e_be;
        logic [31:0] e_addr, e_wd, e_rdata;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic rd, wr, input logic [1:0] size, input logic [31:0] a, wd, input logic [3:0] ws,
        input logic ack, err, input logic [31:0] brd,
        input logic e_stall, e_mis, e_done, e_flt, e_req, e_we, input logic [3:0] e_be,
        input logic [31:0] e_addr, e_wd, e_rdata);
        vec_t v;
        v.rd = rd; v.wr = wr; v.size = size; v.a = a; v.wd = wd; v.ws = ws;
        v.ack = ack; v.err = err; v.brd = brd;
        v.e_stall = e_stall; v.e_mis = e_mis; v.e_done = e_done; v.e_flt = e_flt;
        v.e_req = e_req; v.e_we = e_we; v.e_be = e_be;
        v.e_addr = e_addr; v.e_wd = e_wd; v.e_rdata = e_rdata;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rd, wr, input logic [1:0] size, input logic [31:0] a, wd,
                         input logic [3:0] ws, input logic ack, err, input logic [31:0] brd);
        mem_read = rd; mem_write = wr; mem_size = size; addr = a; wdata = wd; wsel = ws;
        bus.bus_ack = ack; bus.bus_err = err; bus.bus_rdata = brd;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " bus_req"},   32'(bus.bus_req), 32'h0);
        chk({tag, " bus_we"},    32'(bus.bus_we), 32'h0);
        chk({tag, " bus_be"},    32'(bus.bus_be), 32'h0);
        chk({tag, " bus_addr"},  bus.bus_addr, 32'h0);
        chk({tag, " bus_wdata"}, bus.bus_wdata, 32'h0);
        chk({tag, " rdata"},     rdata, 32'h0);
        chk({tag, " done"},      32'(done), 32'h0);
        chk({tag, " fault"},     32'(access_fault), 32'h0);
    endtask

    initial begin
        // A1 = first load word, 55 = error-load word, 12 = back-to-back load word
        vecs.push_back(mk(1,0,0,32'h1006,0,0, 0,0,0,            1,0,0,0,0, 0,4'h0,32'h0,   32'h0, 32'h0));
        vecs.push_back(mk(1,0,0,32'h1006,0,0, 1,0,32'hA1B2C3D4, 1,0,0,0,1, 0,4'hF,32'h1004,32'h0, 32'h0));
        vecs.push_back(mk(0,0,0,0,0,0,        0,0,0,            0,0,1,0,0, 0,4'hF,32'h1004,32'h0, 32'hA1B2C3D4));
        vecs.push_back(mk(0,0,0,0,0,0,        0,0,0,            0,0,0,0,0, 0,4'hF,32'h1004,32'h0, 32'hA1B2C3D4));
        vecs.push_back(mk(0,1,1,32'h2002,32'hBEEF0000,4'hC, 0,0,0, 1,0,0,0,0, 0,4'hF,32'h1004,32'h0, 32'hA1B2C3D4));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0,1,1,32'h2002,32'hBEEF0000,4'hC, 0,0,0, 1,0,0,0,1, 1,4'hC,32'h2000,32'hBEEF0000, 32'hA1B2C3D4));
        vecs.push_back(mk(0,1,1,32'h2002,32'hBEEF0000,4'hC, 1,0,32'h99999999, 1,0,0,0,1, 1,4'hC,32'h2000,32'hBEEF0000, 32'hA1B2C3D4));
        vecs.push_back(mk(0,0,0,0,0,0,        0,0,0,            0,0,1,0,0, 1,4'hC,32'h2000,32'hBEEF0000, 32'hA1B2C3D4));
        vecs.push_back(mk(0,0,0,0,0,0,        0,0,0,            0,0,0,0,0, 1,4'hC,32'h2000,32'hBEEF0000, 32'hA1B2C3D4));
        vecs.push_back(mk(1,0,2,32'h3001,0,0, 0,0,0,            0,1,0,0,0, 1,4'hC,32'h2000,32'hBEEF0000, 32'hA1B2C3D4));
        vecs.push_back(mk(1,0,2,32'h3001,0,0, 0,0,0,            0,1,0,0,0, 1,4'hC,32'h2000,32'hBEEF0000, 32'hA1B2C3D4));
        vecs.push_back(mk(1,0,1,32'h3003,0,0, 0,0,0,            0,1,0,0,0, 1,4'hC,32'h2000,32'hBEEF0000, 32'hA1B2C3D4));
        vecs.push_back(mk(1,0,3,32'h3002,0,0, 0,0,0,            0,1,0,0,0, 1,4'hC,32'h2000,32'hBEEF0000, 32'hA1B2C3D4));
        vecs.push_back(mk(0,0,0,0,0,0,        1,1,32'hFFFFFFFF, 0,0,0,0,0, 1,4'hC,32'h2000,32'hBEEF0000, 32'hA1B2C3D4));
        vecs.push_back(mk(1,0,2,32'h4000,0,0, 0,0,0,            1,0,0,0,0, 1,4'hC,32'h2000,32'hBEEF0000, 32'hA1B2C3D4));
        vecs.push_back(mk(1,0,2,32'h4000,0,0, 1,1,32'h55555555, 1,0,0,0,1, 0,4'hF,32'h4000,32'h0, 32'hA1B2C3D4));
        vecs.push_back(mk(0,0,0,0,0,0,        0,0,0,            0,0,1,1,0, 0,4'hF,32'h4000,32'h0, 32'h55555555));
        vecs.push_back(mk(0,0,0,0,0,0,        0,0,0,            0,0,0,0,0, 0,4'hF,32'h4000,32'h0, 32'h55555555));
        vecs.push_back(mk(1,0,0,32'h5008,0,0, 0,0,0,            1,0,0,0,0, 0,4'hF,32'h4000,32'h0, 32'h55555555));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(1,0,0,32'h5008,0,0, 0,0,0,        1,0,0,0,1, 0,4'hF,32'h5008,32'h0, 32'h55555555));
        vecs.push_back(mk(0,0,0,0,0,0,        0,0,0,            0,0,1,1,0, 0,4'hF,32'h5008,32'h0, 32'h55555555));
        vecs.push_back(mk(0,0,0,0,0,0,        1,0,32'hDEADBEEF, 0,0,0,0,0, 0,4'hF,32'h5008,32'h0, 32'h55555555));
        vecs.push_back(mk(0,0,0,0,0,0,        0,0,0,            0,0,0,0,0, 0,4'hF,32'h5008,32'h0, 32'h55555555));
        vecs.push_back(mk(1,0,2,32'h6000,0,0, 0,0,0,            1,0,0,0,0, 0,4'hF,32'h5008,32'h0, 32'h55555555));
        vecs.push_back(mk(1,0,2,32'h6000,0,0, 1,0,32'h12345678, 1,0,0,0,1, 0,4'hF,32'h6000,32'h0, 32'h55555555));
        vecs.push_back(mk(0,0,0,0,0,0,        0,0,0,            0,0,1,0,0, 0,4'hF,32'h6000,32'h0, 32'h12345678));
        vecs.push_back(mk(1,1,1,32'h6004,32'h0000CAFE,4'h3, 0,0,0, 1,0,0,0,0, 0,4'hF,32'h6000,32'h0, 32'h12345678));
        vecs.push_back(mk(1,1,1,32'h6004,32'h0000CAFE,4'h3, 1,0,32'h77777777, 1,0,0,0,1, 1,4'h3,32'h6004,32'h0000CAFE, 32'h12345678));
        vecs.push_back(mk(0,0,0,0,0,0,        0,0,0,            0,0,1,0,0, 1,4'h3,32'h6004,32'h0000CAFE, 32'h12345678));
        vecs.push_back(mk(0,0,0,0,0,0,        0,0,0,            0,0,0,0,0, 1,4'h3,32'h6004,32'h0000CAFE, 32'h12345678));

        rst_n = 1'b0;
        drive(0,0,0,0,0,0, 0,0,0);
        #12;
        chk_all_zero("reset");
        chk("reset stall", 32'(stall), 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            drive(vecs[i].rd, vecs[i].wr, vecs[i].size, vecs[i].a, vecs[i].wd, vecs[i].ws,
                  vecs[i].ack, vecs[i].err, vecs[i].brd);
            @(negedge clk);
            chk($sformatf("v%0d stall", i),     32'(stall),         32'(vecs[i].e_stall));
            chk($sformatf("v%0d misaligned", i), 32'(misaligned),   32'(vecs[i].e_mis));
            chk($sformatf("v%0d done", i),      32'(done),          32'(vecs[i].e_done));
            chk($sformatf("v%0d fault", i),     32'(access_fault),  32'(vecs[i].e_flt));
            chk($sformatf("v%0d bus_req", i),   32'(bus.bus_req),   32'(vecs[i].e_req));
            chk($sformatf("v%0d bus_we", i),    32'(bus.bus_we),    32'(vecs[i].e_we));
            chk($sformatf("v%0d bus_be", i),    32'(bus.bus_be),    32'(vecs[i].e_be));
            chk($sformatf("v%0d bus_addr", i),  bus.bus_addr,       vecs[i].e_addr);
            chk($sformatf("v%0d bus_wdata", i), bus.bus_wdata,      vecs[i].e_wd);
            chk($sformatf("v%0d rdata", i),     rdata,              vecs[i].e_rdata);
        end

        // reset asserted in cycle 2 of a pending load
        @(posedge clk);
        #1 drive(1,0,2,32'h7000,32'h0,4'h0, 0,0,0);
        @(posedge clk);
        #1;
        chk("rst pre bus_req", 32'(bus.bus_req), 32'h1);
        @(posedge clk);
        #1;
        chk("rst cyc2 bus_req", 32'(bus.bus_req), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        chk_all_zero("rst mid");
        chk("rst mid stall access", 32'(stall), 32'h1);
        drive(0,0,0,0,0,0, 0,0,0);
        #1;
        chk("rst mid stall idle", 32'(stall), 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("post rst %0d bus_req", i), 32'(bus.bus_req), 32'h0);
            chk($sformatf("post rst %0d stall", i),   32'(stall),       32'h0);
            chk($sformatf("post rst %0d done", i),    32'(done),        32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
